// File: rtl/lcd_stream_ctrl.sv
// lcd_stream_ctrl: HD44780 character-LCD controller with power-up init, client FIFO and cursor-tracking line wrap
module lcd_stream_ctrl #(
    parameter int EN_HIGH_CYC    = 20000,
    parameter int EN_LOW_CYC     = 20000,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int POWERUP_CYC    = 1000000,
    parameter int COLS           = 16,
    parameter int ROWS           = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_is_cmd,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       cursor_row,
    output logic [5:0] cursor_col,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic [3:0] lcd_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [3:0] {
        POWERUP = 4'd0,
        INIT    = 4'd1,
        IDLE    = 4'd2,
        SETUP   = 4'd3,
        EN_HIGH = 4'd4,
        EN_LOW  = 4'd5,
        WRAP    = 4'd6
    } state_t;
    state_t state, state_n;
    logic [31:0] cnt, cnt_n, low_lim;
    logic [2:0] init_idx, init_idx_n;
    logic cur_init, cur_init_n, rs_n, row_n, push, pop, long_wait;
    logic [7:0] data_n, init_cmd, wrap_cmd;
    logic [5:0] col_n;
    logic [8:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count, count_n;
    assign push      = wr_valid && wr_ready;
    assign pop       = state == IDLE && count != '0;
    assign count_n   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign init_cmd  = init_idx == 3'd0 ? 8'h38 : init_idx == 3'd1 ? 8'h0C : init_idx == 3'd2 ? 8'h06 : 8'h01;
    assign wrap_cmd  = (ROWS == 1 || cursor_row) ? 8'h80 : 8'hC0;
    assign long_wait = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
    assign low_lim   = long_wait ? 32'(CLEAR_WAIT_CYC) : 32'(EN_LOW_CYC);
    assign busy      = !(state == IDLE && count == '0);
    assign lcd_en    = state == EN_HIGH;
    assign lcd_rw    = 1'b0;
    assign lcd_on    = 1'b1;
    assign lcd_state = state;
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 32'd1;
        init_idx_n = init_idx;
        cur_init_n = cur_init;
        data_n     = lcd_data;
        rs_n       = lcd_rs;
        row_n      = cursor_row;
        col_n      = cursor_col;
        case (state)
            POWERUP: if (cnt == 32'(POWERUP_CYC - 1)) begin
                state_n = INIT;
                cnt_n   = '0;
            end
            INIT: begin
                data_n     = init_cmd;
                rs_n       = 1'b0;
                init_idx_n = init_idx + 3'd1;
                cur_init_n = 1'b1;
                state_n    = SETUP;
                cnt_n      = '0;
            end
            IDLE: begin
                cnt_n = '0;
                if (pop) begin
                    data_n     = mem[rptr][7:0];
                    rs_n       = !mem[rptr][8];
                    cur_init_n = 1'b0;
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = '0;
                state_n = EN_HIGH;
            end
            EN_HIGH: if (cnt == 32'(EN_HIGH_CYC - 1)) begin
                state_n = EN_LOW;
                cnt_n   = '0;
            end
            EN_LOW: if (cnt == low_lim - 32'd1) begin
                cnt_n = '0;
                // the wrap command itself has bit 7 set, so it lands the cursor on the new row, col 0
                if (lcd_rs)
                    col_n = cursor_col + 6'd1;
                else if (long_wait) begin
                    row_n = 1'b0;
                    col_n = '0;
                end else if (lcd_data[7]) begin
                    row_n = ROWS == 1 ? 1'b0 : lcd_data[6];
                    col_n = lcd_data[5:0];
                end
                state_n = cur_init ? (init_idx == 3'd4 ? IDLE : INIT)
                        : (lcd_rs && cursor_col >= 6'(COLS - 1)) ? WRAP : IDLE;
            end
            WRAP: begin
                data_n     = wrap_cmd;
                rs_n       = 1'b0;
                cur_init_n = 1'b0;
                state_n    = SETUP;
                cnt_n      = '0;
            end
            default: state_n = POWERUP;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POWERUP;
            cnt        <= '0;
            init_idx   <= '0;
            cur_init   <= 1'b0;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            cursor_row <= 1'b0;
            cursor_col <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            wr_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            init_idx   <= init_idx_n;
            cur_init   <= cur_init_n;
            lcd_data   <= data_n;
            lcd_rs     <= rs_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            count      <= count_n;
            wr_ready   <= count_n != (AW + 1)'(FIFO_DEPTH);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {wr_is_cmd, wr_data};
endmodule
